// File: rtl/mw_pipe_reg_pkg.sv
// rtl/mw_pipe_reg_pkg.sv - shared load-type codes, reset constants and Tnew helper for the M/W pipeline register
package mw_pipe_reg_pkg;

  localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  // One stage of Tnew has elapsed once the instruction reaches W; never goes below zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/mw_pipe_reg_if.sv
// rtl/mw_pipe_reg_if.sv - M-stage inputs, HCU/CP0 controls and W-stage outputs of the M/W pipeline register
interface mw_pipe_reg_if;

  logic        stall;
  logic        req;
  logic [31:0] M_inStr, M_pc, M_ALU_ans, M_MD_date, M_DM_RD, M_CP0_RD;
  logic [2:0]  M_ld_type;
  logic [1:0]  M_tnew;
  logic        M_jump;
  logic        M_valid;
  logic [31:0] W_inStr, W_pc, W_ALU_ans, W_MD_date, W_DM_RD, W_CP0_RD;
  logic [1:0]  W_tnew;
  logic        W_jump;
  logic        W_valid;
`ifdef RETIRE_CNT_EN
  logic [31:0] W_retire_cnt;

  modport master (
    output stall, req, M_inStr, M_pc, M_ALU_ans, M_MD_date, M_DM_RD, M_CP0_RD,
           M_ld_type, M_tnew, M_jump, M_valid,
    input  W_inStr, W_pc, W_ALU_ans, W_MD_date, W_DM_RD, W_CP0_RD,
           W_tnew, W_jump, W_valid, W_retire_cnt
  );
  modport slave (
    input  stall, req, M_inStr, M_pc, M_ALU_ans, M_MD_date, M_DM_RD, M_CP0_RD,
           M_ld_type, M_tnew, M_jump, M_valid,
    output W_inStr, W_pc, W_ALU_ans, W_MD_date, W_DM_RD, W_CP0_RD,
           W_tnew, W_jump, W_valid, W_retire_cnt
  );
`else
  modport master (
    output stall, req, M_inStr, M_pc, M_ALU_ans, M_MD_date, M_DM_RD, M_CP0_RD,
           M_ld_type, M_tnew, M_jump, M_valid,
    input  W_inStr, W_pc, W_ALU_ans, W_MD_date, W_DM_RD, W_CP0_RD,
           W_tnew, W_jump, W_valid
  );
  modport slave (
    input  stall, req, M_inStr, M_pc, M_ALU_ans, M_MD_date, M_DM_RD, M_CP0_RD,
           M_ld_type, M_tnew, M_jump, M_valid,
    output W_inStr, W_pc, W_ALU_ans, W_MD_date, W_DM_RD, W_CP0_RD,
           W_tnew, W_jump, W_valid
  );
`endif

endinterface

// File: rtl/mw_pipe_reg_load_ext.sv
// rtl/mw_pipe_reg_load_ext.sv - combinational sub-word selection and sign/zero extension of a DM read word
module load_ext
  import mw_pipe_reg_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_type,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word >> {off, 3'b000};
    byte_sel = shifted[7:0];
    // Halfword loads are trapped upstream when misaligned, so only off[1] selects.
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (ld_type)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'd0, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mw_pipe_reg.sv
// rtl/mw_pipe_reg.sv - M/W pipeline register with load extension, flush, stall and Tnew countdown
// Optional W_retire_cnt retired-instruction counter when RETIRE_CNT_EN is defined.
module mw_pipe_reg
  import mw_pipe_reg_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mw_pipe_reg_if.slave mw
);

  logic [31:0] dm_ext;
  logic [31:0] instr_q, pc_q, alu_q, md_q, dm_q, cp0_q;
  logic [1:0]  tnew_q;
  logic        jump_q, valid_q;

  load_ext u_load_ext (
    .word    (mw.M_DM_RD),
    .off     (mw.M_ALU_ans[1:0]),
    .ld_type (mw.M_ld_type),
    .data    (dm_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= PC_RESET;
      alu_q   <= 32'd0;
      md_q    <= 32'd0;
      dm_q    <= 32'd0;
      cp0_q   <= 32'd0;
      tnew_q  <= 2'd0;
      jump_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (mw.req) begin
      // Bubble keeps the M-stage PC so CP0 can still record EPC.
      instr_q <= NOP_INSTR;
      pc_q    <= mw.M_pc;
      alu_q   <= 32'd0;
      md_q    <= 32'd0;
      dm_q    <= 32'd0;
      cp0_q   <= 32'd0;
      tnew_q  <= 2'd0;
      jump_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (!mw.stall) begin
      instr_q <= mw.M_inStr;
      pc_q    <= mw.M_pc;
      alu_q   <= mw.M_ALU_ans;
      md_q    <= mw.M_MD_date;
      dm_q    <= dm_ext;
      cp0_q   <= mw.M_CP0_RD;
      tnew_q  <= tnew_dec(mw.M_tnew);
      jump_q  <= mw.M_jump;
      valid_q <= mw.M_valid;
    end
  end

  assign mw.W_inStr   = instr_q;
  assign mw.W_pc      = pc_q;
  assign mw.W_ALU_ans = alu_q;
  assign mw.W_MD_date = md_q;
  assign mw.W_DM_RD   = dm_q;
  assign mw.W_CP0_RD  = cp0_q;
  assign mw.W_tnew    = tnew_q;
  assign mw.W_jump    = jump_q;
  assign mw.W_valid   = valid_q;

`ifdef RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_q <= 32'd0;
    end else if (!mw.req && !mw.stall && mw.M_valid) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign mw.W_retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_mw_pipe_reg.sv
// tb/tb_mw_pipe_reg.sv - directed plus randomized bench for mw_pipe_reg against a behavioural model
module tb_mw_pipe_reg;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mw_pipe_reg_if ifc ();

  mw_pipe_reg dut (
    .clk   (clk),
    .reset (reset),
    .mw    (ifc)
  );

  logic [31:0] e_instr, e_pc, e_alu, e_md, e_dm, e_cp0, e_cnt;
  logic [1:0]  e_tnew;
  logic        e_jump, e_valid;

  function automatic logic [31:0] ext_model(input logic [31:0] word, input int off, input int ty);
    int unsigned b, h;
    b = (word / (32'd1 << (8 * off))) % 256;
    h = (word / ((off >= 2) ? 32'd65536 : 32'd1)) % 65536;
    case (ty)
      1:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      2:       return b;
      3:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4:       return h;
      default: return word;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".instr"}, ifc.W_inStr, e_instr);
    chk({where, ".pc"},    ifc.W_pc, e_pc);
    chk({where, ".alu"},   ifc.W_ALU_ans, e_alu);
    chk({where, ".md"},    ifc.W_MD_date, e_md);
    chk({where, ".dm"},    ifc.W_DM_RD, e_dm);
    chk({where, ".cp0"},   ifc.W_CP0_RD, e_cp0);
    chk({where, ".tnew"},  {30'd0, ifc.W_tnew}, {30'd0, e_tnew});
    chk({where, ".jump"},  {31'd0, ifc.W_jump}, {31'd0, e_jump});
    chk({where, ".valid"}, {31'd0, ifc.W_valid}, {31'd0, e_valid});
`ifdef RETIRE_CNT_EN
    chk({where, ".cnt"},   ifc.W_retire_cnt, e_cnt);
`endif
  endtask

  task automatic model_reset();
    e_instr = 32'h0; e_pc = 32'h3000; e_alu = 0; e_md = 0; e_dm = 0; e_cp0 = 0;
    e_tnew = 0; e_jump = 0; e_valid = 0; e_cnt = 0;
  endtask

  task automatic set_rand();
    ifc.M_inStr   = $urandom;
    ifc.M_pc      = $urandom;
    ifc.M_ALU_ans = $urandom;
    ifc.M_MD_date = $urandom;
    ifc.M_DM_RD   = $urandom;
    ifc.M_CP0_RD  = $urandom;
    ifc.M_ld_type = 3'($urandom_range(0, 7));
    ifc.M_tnew    = 2'($urandom_range(0, 3));
    ifc.M_jump    = 1'($urandom_range(0, 1));
    ifc.M_valid   = 1'($urandom_range(0, 1));
  endtask

  // Advance one clock: predict W from the current M inputs, then compare just after the edge.
  task automatic step(input string where);
    if (ifc.req) begin
      e_instr = 0; e_pc = ifc.M_pc; e_alu = 0; e_md = 0; e_dm = 0; e_cp0 = 0;
      e_tnew = 0; e_jump = 0; e_valid = 0;
    end else if (!ifc.stall) begin
      e_instr = ifc.M_inStr;
      e_pc    = ifc.M_pc;
      e_alu   = ifc.M_ALU_ans;
      e_md    = ifc.M_MD_date;
      e_dm    = ext_model(ifc.M_DM_RD, int'(ifc.M_ALU_ans % 4), int'(ifc.M_ld_type));
      e_cp0   = ifc.M_CP0_RD;
      e_tnew  = (ifc.M_tnew > 0) ? ifc.M_tnew - 2'd1 : 2'd0;
      e_jump  = ifc.M_jump;
      e_valid = ifc.M_valid;
      if (ifc.M_valid) e_cnt = e_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  initial begin
    ifc.stall = 0; ifc.req = 0;
    set_rand();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    set_rand(); ifc.M_valid = 1;
    ifc.M_DM_RD = 32'h80FF_7F01; ifc.M_ALU_ans = {ifc.M_ALU_ans[31:2], 2'd3}; ifc.M_ld_type = 3'd1;
    step("lb");
    chk("lb_const", ifc.W_DM_RD, 32'hFFFF_FF80);

    ifc.M_ALU_ans = {ifc.M_ALU_ans[31:2], 2'd1}; ifc.M_ld_type = 3'd2;
    step("lbu");
    chk("lbu_const", ifc.W_DM_RD, 32'h0000_007F);

    ifc.M_ALU_ans = {ifc.M_ALU_ans[31:2], 2'd2}; ifc.M_ld_type = 3'd3;
    step("lh");
    chk("lh_const", ifc.W_DM_RD, 32'hFFFF_80FF);

    ifc.M_tnew = 2'd2; step("tnew2"); chk("tnew2_const", {30'd0, ifc.W_tnew}, 32'd1);
    ifc.M_tnew = 2'd1; step("tnew1"); chk("tnew1_const", {30'd0, ifc.W_tnew}, 32'd0);
    ifc.M_tnew = 2'd0; step("tnew0"); chk("tnew0_const", {30'd0, ifc.W_tnew}, 32'd0);

    ifc.stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      step("stall");
    end

    ifc.req = 1; ifc.M_pc = 32'h3010;
    step("flush");
    chk("flush_pc_const", ifc.W_pc, 32'h3010);
    chk("flush_valid_const", {31'd0, ifc.W_valid}, 32'd0);
    ifc.req = 0;

    set_rand(); ifc.M_valid = 1;
    step("pre_rst");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    reset = 1'b1;

    for (int i = 0; i < 400; i++) begin
      set_rand();
      ifc.stall = ($urandom_range(0, 3) == 0);
      ifc.req   = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
